// File: rtl/reg_wb_queue.sv
// In-order write-back queue between the execute units and the register-file write port.
// Also provides two youngest-match lookup ports so decode can forward queued values.
module reg_wb_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_op,
    input  logic [4:0]       in_reg_idx,
    input  logic [31:0]      in_reg_val,
    output logic             in_ready,
    output logic             out_op,
    output logic [4:0]       out_reg_idx,
    output logic [31:0]      out_reg_val,
    input  logic             out_ready,
    input  logic [4:0]       lookup_idx0,
    output logic             lookup_hit0,
    output logic [31:0]      lookup_val0,
    input  logic [4:0]       lookup_idx1,
    output logic             lookup_hit1,
    output logic [31:0]      lookup_val1,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [DEPTH-1:0] valid_r;
    logic [4:0]       idx_r [DEPTH];
    logic [31:0]      val_r [DEPTH];
    logic             push_s;
    logic             pop_s;
    logic [32:0]      look0_s;
    logic [32:0]      look1_s;

    // Walk from oldest (rd_ptr) to youngest so the last match seen is the youngest one.
    function automatic logic [32:0] lookup_fn(input logic [4:0] key);
        logic [32:0]      res;
        logic [PTR_W-1:0] slot;
        res = 33'd0;
        if (key != 5'd0) begin
            for (int k = 0; k < DEPTH; k++) begin
                slot = rd_ptr_r + PTR_W'(k);
                if (valid_r[slot] && (idx_r[slot] == key)) begin
                    res = {1'b1, val_r[slot]};
                end
            end
        end
        return res;
    endfunction

    // Handshake decode; a full queue refuses pushes even while it pops.
    always_comb begin
        in_ready = (count_r != FULL_CNT);
        out_op   = (count_r != {(PTR_W + 1){1'b0}});
        push_s   = in_op && in_ready && (in_reg_idx != 5'd0);
        pop_s    = out_op && out_ready;
        count    = count_r;
    end

    // Head entry presented to the register file, zeroed when empty.
    always_comb begin
        out_reg_idx = 5'd0;
        out_reg_val = 32'd0;
        if (out_op) begin
            out_reg_idx = idx_r[rd_ptr_r];
            out_reg_val = val_r[rd_ptr_r];
        end else begin
            out_reg_idx = 5'd0;
            out_reg_val = 32'd0;
        end
    end

    // Forwarding lookups for both decode read ports.
    always_comb begin
        look0_s     = lookup_fn(lookup_idx0);
        look1_s     = lookup_fn(lookup_idx1);
        lookup_hit0 = look0_s[32];
        lookup_val0 = look0_s[31:0];
        lookup_hit1 = look1_s[32];
        lookup_val1 = look1_s[31:0];
    end

    // Pointer, occupancy and valid-bit state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W + 1){1'b0}};
            valid_r  <= {DEPTH{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r          <= wr_ptr_r + {{(PTR_W - 1){1'b0}}, 1'b1};
                valid_r[wr_ptr_r] <= 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r          <= rd_ptr_r + {{(PTR_W - 1){1'b0}}, 1'b1};
                valid_r[rd_ptr_r] <= 1'b0;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{PTR_W{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{PTR_W{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry payload storage; contents are qualified by valid_r so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            idx_r[wr_ptr_r] <= in_reg_idx;
            val_r[wr_ptr_r] <= in_reg_val;
        end
    end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue: reset, x0 drop, backpressure, forwarding, wrap, async reset.
module tb_reg_wb_queue;

    logic        clk;
    logic        rst_n;
    logic        in_op;
    logic [4:0]  in_reg_idx;
    logic [31:0] in_reg_val;
    logic        in_ready;
    logic        out_op;
    logic [4:0]  out_reg_idx;
    logic [31:0] out_reg_val;
    logic        out_ready;
    logic [4:0]  lookup_idx0;
    logic        lookup_hit0;
    logic [31:0] lookup_val0;
    logic [4:0]  lookup_idx1;
    logic        lookup_hit1;
    logic [31:0] lookup_val1;
    logic [2:0]  count;

    int vectors = 0;
    int miscompares = 0;

    reg_wb_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_op(in_op), .in_reg_idx(in_reg_idx), .in_reg_val(in_reg_val), .in_ready(in_ready),
        .out_op(out_op), .out_reg_idx(out_reg_idx), .out_reg_val(out_reg_val), .out_ready(out_ready),
        .lookup_idx0(lookup_idx0), .lookup_hit0(lookup_hit0), .lookup_val0(lookup_val0),
        .lookup_idx1(lookup_idx1), .lookup_hit1(lookup_hit1), .lookup_val1(lookup_val1),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_op = 1'b0; in_reg_idx = 5'd0; in_reg_val = 32'd0;
        out_ready = 1'b0; lookup_idx0 = 5'd5; lookup_idx1 = 5'd0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_op", 32'(out_op), 32'd0);
        chk("rst_out_idx", 32'(out_reg_idx), 32'd0);
        chk("rst_out_val", out_reg_val, 32'd0);
        chk("rst_hit0", 32'(lookup_hit0), 32'd0);
        chk("rst_val0", lookup_val0, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        tick();

        // single push then drain
        in_op = 1'b1; in_reg_idx = 5'd5; in_reg_val = 32'h12345000;
        #1;
        chk("s1_no_passthru", 32'(out_op), 32'd0);
        chk("s1_no_lookup_same_cycle", 32'(lookup_hit0), 32'd0);
        tick();
        in_op = 1'b0;
        #1;
        chk("s1_out_op", 32'(out_op), 32'd1);
        chk("s1_out_idx", 32'(out_reg_idx), 32'd5);
        chk("s1_out_val", out_reg_val, 32'h12345000);
        chk("s1_count", 32'(count), 32'd1);
        chk("s1_hit0", 32'(lookup_hit0), 32'd1);
        chk("s1_val0", lookup_val0, 32'h12345000);
        out_ready = 1'b1;
        #1;
        chk("s1_popped_still_visible", 32'(lookup_hit0), 32'd1);
        tick();
        chk("s1_drained_out_op", 32'(out_op), 32'd0);
        chk("s1_drained_count", 32'(count), 32'd0);
        chk("s1_drained_hit0", 32'(lookup_hit0), 32'd0);

        // x0 request is accepted but dropped
        in_op = 1'b1; in_reg_idx = 5'd0; in_reg_val = 32'hFFFFFFFF;
        #1;
        chk("x0_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_op = 1'b0;
        #1;
        chk("x0_count", 32'(count), 32'd0);
        chk("x0_out_op", 32'(out_op), 32'd0);

        // fill to full under backpressure
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_op = 1'b1; in_reg_idx = 5'(i); in_reg_val = 32'(i * 16);
            tick();
        end
        in_op = 1'b0;
        #1;
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        in_op = 1'b1; in_reg_idx = 5'd9; in_reg_val = 32'h99;
        out_ready = 1'b1;
        #1;
        chk("full_in_ready_while_pop", 32'(in_ready), 32'd0);
        out_ready = 1'b0;
        tick();
        in_op = 1'b0; lookup_idx0 = 5'd9;
        #1;
        chk("full_push_lost_count", 32'(count), 32'd4);
        chk("full_push_lost_hit", 32'(lookup_hit0), 32'd0);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk("drain_idx", 32'(out_reg_idx), 32'(i));
            chk("drain_val", out_reg_val, 32'(i * 16));
            tick();
        end
        chk("drain_empty_count", 32'(count), 32'd0);
        chk("drain_empty_out_op", 32'(out_op), 32'd0);

        // youngest-wins forwarding
        out_ready = 1'b0;
        in_op = 1'b1; in_reg_idx = 5'd7; in_reg_val = 32'hAAAA0000;
        tick();
        in_reg_val = 32'hBBBB0000;
        tick();
        in_op = 1'b0; lookup_idx0 = 5'd7; lookup_idx1 = 5'd8;
        #1;
        chk("fwd_hit0", 32'(lookup_hit0), 32'd1);
        chk("fwd_val0", lookup_val0, 32'hBBBB0000);
        chk("fwd_hit1", 32'(lookup_hit1), 32'd0);
        chk("fwd_val1", lookup_val1, 32'd0);
        lookup_idx1 = 5'd0;
        #1;
        chk("fwd_x0_hit1", 32'(lookup_hit1), 32'd0);
        chk("fwd_head_val", out_reg_val, 32'hAAAA0000);
        out_ready = 1'b1;
        tick();
        chk("fwd_second_val", out_reg_val, 32'hBBBB0000);
        chk("fwd_second_hit0", 32'(lookup_hit0), 32'd1);
        tick();
        chk("fwd_empty_count", 32'(count), 32'd0);

        // continuous push with pop, crossing pointer wrap
        for (int i = 0; i < 10; i++) begin
            in_op = 1'b1; in_reg_idx = 5'(3 + i); in_reg_val = 32'h100 + 32'(i);
            tick();
            chk("stream_count", 32'(count), 32'd1);
            chk("stream_idx", 32'(out_reg_idx), 32'(3 + i));
            chk("stream_val", out_reg_val, 32'h100 + 32'(i));
        end
        in_op = 1'b0;
        tick();
        chk("stream_empty_count", 32'(count), 32'd0);

        // asynchronous reset with entries queued
        out_ready = 1'b0; lookup_idx0 = 5'd2; lookup_idx1 = 5'd3;
        for (int i = 1; i <= 3; i++) begin
            in_op = 1'b1; in_reg_idx = 5'(i); in_reg_val = 32'(i);
            tick();
        end
        in_op = 1'b0;
        #1;
        chk("pre_rst_count", 32'(count), 32'd3);
        chk("pre_rst_hit0", 32'(lookup_hit0), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_op", 32'(out_op), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_hit0", 32'(lookup_hit0), 32'd0);
        chk("arst_hit1", 32'(lookup_hit1), 32'd0);
        chk("arst_out_val", out_reg_val, 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        #2;
        rst_n = 1'b1;
        tick();
        in_op = 1'b1; in_reg_idx = 5'd5; in_reg_val = 32'h12345000;
        tick();
        in_op = 1'b0;
        #1;
        chk("post_rst_out_op", 32'(out_op), 32'd1);
        chk("post_rst_idx", 32'(out_reg_idx), 32'd5);
        chk("post_rst_val", out_reg_val, 32'h12345000);
        chk("post_rst_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("post_rst_drained", 32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
